fifo_rd_stream_a16d36: RTL and testbench

Read-side drain engine for the 16x36 single-clock FIFO envelope. It watches the FIFO `empty` flag, issues `rd_op` pops, captures `rd_data` one cycle after each pop, and presents the words on a valid/ready stream toward the consumer. A 2-entry output buffer sustains one word per cycle and never loses a word under consumer backpressure. It sits between the FIFO envelope read port and any downstream datapath engine.

---
 rtl/fifo_rd_stream_a16d36_if.sv | 30 +++
 rtl/fifo_rd_stream_a16d36.sv | 82 ++++++++
 tb/tb_fifo_rd_stream_a16d36.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_a16d36_if.sv
// Read-port and output-stream bundle for the 16x36 FIFO drain engine.
// The master side is the drain engine; the slave side is the FIFO envelope plus the consumer.
interface fifo_rd_stream_a16d36_if #(
    parameter int DAT_WIDTH = 36
);
    logic                 fifo_empty;
    logic                 fifo_rd_op;
    logic [DAT_WIDTH-1:0] fifo_rd_data;
    logic                 out_valid;
    logic [DAT_WIDTH-1:0] out_data;
    logic                 out_ready;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  out_ready,
        output fifo_rd_op,
        output out_valid,
        output out_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output out_ready,
        input  fifo_rd_op,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fifo_rd_stream_a16d36.sv
// Drain engine: pops the FIFO, captures read data a cycle later into a 2-entry
// skid buffer and presents it on a valid/ready stream with credit-based pop control.
module fifo_rd_stream_a16d36 #(
    parameter int PTR_WIDTH = 4,
    parameter int DAT_WIDTH = 36,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sreset_n,
    input  logic                       drain_en,
    fifo_rd_stream_a16d36_if.master    bus,
    output logic [CNT_WIDTH-1:0]       pop_cnt,
    output logic                       busy
);

    if (PTR_WIDTH < 1) begin : g_bad_ptr_width
        $error("PTR_WIDTH must be at least 1");
    end

    logic                 r_inflight;
    logic [1:0]           r_occ;
    logic                 r_wptr;
    logic                 r_rptr;
    logic [CNT_WIDTH-1:0] r_pop_cnt;
    logic [DAT_WIDTH-1:0] r_buf [2];

    logic                 w_acc;
    logic                 w_rd_op;
    logic [1:0]           w_level;

    // w_level is the occupancy after this edge; a pop is only allowed if its
    // word will still find a free slot when it lands one cycle later.
    assign w_acc   = (r_occ != 2'd0) & bus.out_ready;
    assign w_level = r_occ + {1'b0, r_inflight} - {1'b0, w_acc};
    assign w_rd_op = drain_en & ~bus.fifo_empty & sreset_n & (w_level < 2'd2);

    assign bus.fifo_rd_op = w_rd_op;
    assign bus.out_valid  = (r_occ != 2'd0);
    assign bus.out_data   = r_buf[r_rptr];
    assign pop_cnt        = r_pop_cnt;
    assign busy           = r_inflight | (r_occ != 2'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_pop_cnt  <= '0;
        end else if (!sreset_n) begin
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_pop_cnt  <= '0;
        end else begin
            r_inflight <= w_rd_op;
            r_occ      <= w_level;
            if (r_inflight) begin
                r_wptr <= ~r_wptr;
            end
            if (w_acc) begin
                r_rptr <= ~r_rptr;
            end
            if (w_rd_op) begin
                r_pop_cnt <= r_pop_cnt + 1'b1;
            end
        end
    end

    // A word in flight during a soft clear is dropped rather than captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else if (sreset_n && r_inflight) begin
            r_buf[r_wptr] <= bus.fifo_rd_data;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_a16d36.sv
// Scoreboard bench for the FIFO drain engine: a behavioural FIFO feeds the DUT,
// expected words are queued at push time and a negedge monitor checks the stream.
module tb_fifo_rd_stream_a16d36;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sreset_n = 1'b1;
    logic drain_en = 1'b0;
    logic out_ready = 1'b0;
    logic [15:0] pop_cnt;
    logic busy;

    fifo_rd_stream_a16d36_if #(.DAT_WIDTH(36)) bus ();

    fifo_rd_stream_a16d36 #(
        .PTR_WIDTH(4),
        .DAT_WIDTH(36),
        .CNT_WIDTH(16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sreset_n (sreset_n),
        .drain_en (drain_en),
        .bus      (bus),
        .pop_cnt  (pop_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Behavioural FIFO: read data appears the cycle after a pop.
    logic [35:0] mem [0:63];
    int wr_i = 0;
    int rd_i = 0;
    logic [35:0] sb [$];

    assign bus.fifo_empty = (wr_i == rd_i);
    assign bus.out_ready  = out_ready;

    initial bus.fifo_rd_data = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd_op) begin
            bus.fifo_rd_data <= mem[rd_i % 64];
            rd_i <= rd_i + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [35:0] w, input bit expect_out);
        mem[wr_i % 64] = w;
        wr_i++;
        if (expect_out) sb.push_back(w);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference occupancy / in-flight state tracked from the observable handshake.
    int m_occ = 0;
    int m_inf = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_occ <= 0;
            m_inf <= 0;
        end else if (!sreset_n) begin
            m_occ <= 0;
            m_inf <= 0;
        end else begin
            m_occ <= m_occ + m_inf - ((m_occ != 0 && out_ready) ? 1 : 0);
            m_inf <= bus.fifo_rd_op ? 1 : 0;
        end
    end

    int first_pop = -1;
    int first_val = -1;
    int pops_seen = 0;
    int acc_cyc [$];
    bit prev_stall = 1'b0;
    logic [35:0] prev_data = '0;

    always @(negedge clk) begin : mon
        int acc_m;
        bit exp_op;
        logic [35:0] e;
        if (reset_n) begin
            acc_m  = (m_occ != 0 && out_ready) ? 1 : 0;
            exp_op = drain_en && !bus.fifo_empty && sreset_n && (m_occ + m_inf - acc_m < 2);
            chk("rd_op_rule", bus.fifo_rd_op, exp_op);
            chk("out_valid", bus.out_valid, m_occ != 0);
            chk("busy", busy, (m_inf != 0) || (m_occ != 0));
            if (bus.fifo_rd_op) begin
                pops_seen++;
                if (first_pop < 0) first_pop = cyc;
            end
            if (bus.out_valid && first_val < 0) first_val = cyc;
            if (prev_stall && bus.out_valid) chk("data_stable", bus.out_data, prev_data);
            if (bus.out_valid && out_ready) begin
                acc_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_word", bus.out_data, 64'hDEAD_BEEF);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", bus.out_data, e);
                end
            end
            prev_stall = bus.out_valid && !out_ready;
            prev_data  = bus.out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic wait_idle(input string nm, input int limit);
        int n;
        n = 0;
        while (!(busy == 1'b0 && bus.fifo_empty && sb.size() == 0) && n < limit) begin
            step(1);
            n++;
        end
        chk(nm, (n >= limit), 1'b0);
    endtask

    task automatic soft_clear();
        sreset_n = 1'b0;
        step(1);
        sreset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bit stuck;
        logic [15:0] roll_exp [3];
        roll_exp[0] = 16'hFFFF;
        roll_exp[1] = 16'h0000;
        roll_exp[2] = 16'h0001;

        // Reset state
        step(3);
        chk("rst_rd_op", bus.fifo_rd_op, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 36'h0);
        chk("rst_pop_cnt", pop_cnt, 16'h0);
        chk("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        step(2);

        // Basic ordered drain with latency and back-to-back output
        drain_en  = 1'b1;
        out_ready = 1'b1;
        acc_cyc.delete();
        first_pop = -1;
        first_val = -1;
        for (int i = 1; i <= 4; i++) push(36'(i), 1'b1);
        wait_idle("t1_idle", 200);
        chk("t1_latency", 64'(first_val - first_pop), 64'd2);
        chk("t1_count", 64'(acc_cyc.size()), 64'd4);
        if (acc_cyc.size() == 4) chk("t1_no_gaps", 64'(acc_cyc[3] - acc_cyc[0]), 64'd3);
        chk("t1_pop_cnt", pop_cnt, 16'd4);
        chk("t1_busy", busy, 1'b0);

        // Full FIFO with a 10-cycle consumer stall
        soft_clear();
        out_ready = 1'b0;
        acc_cyc.delete();
        pops_seen = 0;
        for (int i = 0; i < 16; i++) push(36'h100 + 36'(i), 1'b1);
        step(10);
        chk("t2_stall_pops", 64'(pops_seen), 64'd2);
        chk("t2_stall_valid", bus.out_valid, 1'b1);
        chk("t2_stall_head", bus.out_data, 36'h100);
        out_ready = 1'b1;
        wait_idle("t2_idle", 200);
        chk("t2_count", 64'(acc_cyc.size()), 64'd16);
        if (acc_cyc.size() == 16) chk("t2_no_gaps", 64'(acc_cyc[15] - acc_cyc[0]), 64'd15);
        chk("t2_pop_cnt", pop_cnt, 16'd16);

        // Alternating consumer ready
        soft_clear();
        for (int i = 0; i < 8; i++) push(36'h200 + 36'(i), 1'b1);
        guard = 0;
        while (!(busy == 1'b0 && bus.fifo_empty && sb.size() == 0) && guard < 100) begin
            out_ready = ~guard[0];
            step(1);
            guard++;
        end
        chk("t3_done", (guard >= 100), 1'b0);
        chk("t3_pop_cnt", pop_cnt, 16'd8);

        // Soft clear with one word in flight and one buffered: B, C are discarded
        soft_clear();
        out_ready = 1'b0;
        push(36'h300, 1'b1);
        push(36'h301, 1'b0);
        push(36'h302, 1'b0);
        push(36'h303, 1'b1);
        push(36'h304, 1'b1);
        step(4);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("t4_pre_busy", busy, 1'b1);
        sreset_n = 1'b0;
        #1;
        chk("t4_rd_op_forced_low", bus.fifo_rd_op, 1'b0);
        step(1);
        sreset_n = 1'b1;
        chk("t4_clr_valid", bus.out_valid, 1'b0);
        chk("t4_clr_busy", busy, 1'b0);
        chk("t4_clr_pop_cnt", pop_cnt, 16'd0);
        out_ready = 1'b1;
        wait_idle("t4_idle", 200);
        chk("t4_pop_cnt", pop_cnt, 16'd2);

        // drain_en gating while buffered words drain
        soft_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(36'h400 + 36'(i), 1'b1);
        step(4);
        drain_en  = 1'b0;
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_no_pop", bus.fifo_rd_op, 1'b0);
            step(1);
        end
        chk("t5_drained", bus.out_valid, 1'b0);
        chk("t5_pop_cnt_hold", pop_cnt, 16'd2);
        drain_en = 1'b1;
        #1;
        chk("t5_resume_same_cycle", bus.fifo_rd_op, 1'b1);
        wait_idle("t5_idle", 200);
        chk("t5_pop_cnt", pop_cnt, 16'd5);

        // pop_cnt rollover
        soft_clear();
        drain_en  = 1'b1;
        out_ready = 1'b1;
        stuck = 1'b0;
        for (int k = 0; k < 65534; k++) begin
            guard = 0;
            while ((wr_i - rd_i) >= 32 && guard < 1000) begin
                step(1);
                guard++;
            end
            if (guard >= 1000) begin
                stuck = 1'b1;
                break;
            end
            push(36'hA_0000_0000 | 36'(k), 1'b1);
        end
        chk("t6_bulk_progress", stuck, 1'b0);
        wait_idle("t6_bulk_idle", 2000);
        chk("t6_pop_cnt_fffe", pop_cnt, 16'hFFFE);
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) push(36'hB00 + 36'(i), 1'b1);
        step(1);
        for (int i = 0; i < 3; i++) begin
            drain_en = 1'b1;
            step(1);
            drain_en = 1'b0;
            chk("t6_rollover", pop_cnt, roll_exp[i]);
        end
        wait_idle("t6_idle", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
